// File: rtl/addm_datapath_ctrl.sv
// addm_datapath_ctrl -- adding-machine core with its own sequencer.
//
// Accumulator, instruction register and program counter, driven by a
// fetch/decode/execute FSM that reads program and operands over a
// request/acknowledge memory port with unlimited wait states.
//
// Optional feature macro: ADDM_SUB_EN
//   defined   : opcode 01 is SUB (acc - M[a], carry = borrow)
//   undefined : opcode 01 is AND (acc & M[a], carry cleared)
//
// Ports
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   start       in   one-cycle pulse, starts a run at address 0 (IDLE/HALT only)
//   mem_req     out  memory read request
//   mem_addr    out  read address, valid while mem_req=1
//   mem_rdata   in   read data, valid with mem_ack
//   mem_ack     in   read completion, only looked at while mem_req=1
//   out_acc     out  accumulator
//   out_ir      out  instruction register
//   out_pc      out  program counter
//   carry       out  carry (ADD) / borrow (SUB) flag
//   zero        out  last ALU result was zero
//   busy        out  high in FETCH, DECODE, EXEC
//   halted      out  high in HALT
module addm_datapath_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] out_acc,
  output logic [DATA_W-1:0] out_ir,
  output logic [ADDR_W-1:0] out_pc,
  output logic              carry,
  output logic              zero,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  // ALU result with the carry/borrow in the extra top bit.
  function automatic logic [DATA_W:0] alu(input logic [1:0]        op,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    if (op == OP_ADD)
      return {1'b0, a} + {1'b0, b};
`ifdef ADDM_SUB_EN
    // Borrow shows up as the top bit of the zero-extended difference.
    return {1'b0, a} - {1'b0, b};
`else
    return {1'b0, a & b};
`endif
  endfunction

  state_t              r_state;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_ir;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_carry;
  logic                r_zero;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_busy;
  logic                r_halted;

  logic [1:0]          w_opcode;
  logic [ADDR_W-1:0]   w_operand;
  logic [DATA_W:0]     w_alu;

  assign w_opcode  = r_ir[DATA_W-1:DATA_W-2];
  assign w_operand = r_ir[ADDR_W-1:0];
  assign w_alu     = alu(w_opcode, r_acc, mem_rdata);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_ir       <= '0;
      r_pc       <= '0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        // IDLE and HALT share the run initialisation; start is only
        // honoured here, so it is ignored while busy.
        S_IDLE, S_HALT: begin
          if (start) begin
            r_pc       <= '0;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_mem_req  <= 1'b1;
            r_mem_addr <= '0;
            r_busy     <= 1'b1;
            r_halted   <= 1'b0;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            r_ir      <= mem_rdata;
            r_pc      <= r_pc + 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (w_opcode)
            OP_JMP: begin
              // Overrides the increment done in FETCH.
              r_pc       <= w_operand;
              r_mem_req  <= 1'b1;
              r_mem_addr <= w_operand;
              r_state    <= S_FETCH;
            end
            OP_HALT: begin
              r_busy   <= 1'b0;
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end
            default: begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= w_operand;
              r_state    <= S_EXEC;
            end
          endcase
        end
        S_EXEC: begin
          if (mem_ack) begin
            {r_carry, r_acc} <= w_alu;
            r_zero           <= (w_alu[DATA_W-1:0] == '0);
            r_mem_addr       <= r_pc;
            r_state          <= S_FETCH;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_halted  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign out_acc  = r_acc;
  assign out_ir   = r_ir;
  assign out_pc   = r_pc;
  assign carry    = r_carry;
  assign zero     = r_zero;
  assign busy     = r_busy;
  assign halted   = r_halted;

endmodule

// File: tb/tb_addm_datapath_ctrl.sv
// Testbench for addm_datapath_ctrl (DATA_W=8, ADDR_W=6): directed program
// scenarios plus randomized programs checked against an instruction-level
// reference interpreter.
module tb_addm_datapath_ctrl;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       mem_req;
  logic [5:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [7:0] out_acc;
  logic [7:0] out_ir;
  logic [5:0] out_pc;
  logic       carry;
  logic       zero;
  logic       busy;
  logic       halted;

  addm_datapath_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .out_acc  (out_acc),
    .out_ir   (out_ir),
    .out_pc   (out_pc),
    .carry    (carry),
    .zero     (zero),
    .busy     (busy),
    .halted   (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model with a programmable number of wait cycles per access.
  logic [7:0] mem [64];
  int         wait_n;
  int         wcnt;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (wcnt >= wait_n);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 wcnt <= 0;
    else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                          wcnt <= 0;
  end

  int checks;
  int failures;
  int run_cycles;

  // Reference results
  int exp_acc, exp_pc, exp_ir, exp_cyc;
  int exp_c, exp_z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction-level interpreter: executes the program in mem and totals
  // cycles with the documented per-instruction latencies.
  task automatic model(input int waits);
    int acc, pc, ir, op, a, m, steps;
    int c, z;
    bit done;
    acc = 0; pc = 0; ir = 0; c = 0; z = 0; done = 0; steps = 0;
    exp_cyc = 0;
    while (!done && steps < 500) begin
      ir = int'(mem[pc]);
      pc = (pc + 1) % 64;
      op = ir / 64;
      a  = ir % 64;
      m  = int'(mem[a]);
      steps++;
      if (op == 0) begin
        acc = acc + m;
        c = (acc > 255) ? 1 : 0;
        acc = acc % 256;
        z = (acc == 0) ? 1 : 0;
        exp_cyc += 3 + 2 * waits;
      end else if (op == 1) begin
`ifdef ADDM_SUB_EN
        c = (m > acc) ? 1 : 0;
        acc = (acc - m + 256) % 256;
`else
        acc = acc & m;
        c = 0;
`endif
        z = (acc == 0) ? 1 : 0;
        exp_cyc += 3 + 2 * waits;
      end else if (op == 2) begin
        pc = a;
        exp_cyc += 2 + waits;
      end else begin
        exp_cyc += 2 + waits;
        done = 1;
      end
    end
    exp_acc = acc; exp_pc = pc; exp_ir = ir; exp_c = c; exp_z = z;
  endtask

  // Starts a run (called on a falling edge) and follows it to HALT.
  // While a wait cycle is in progress, checks that the request and the
  // architectural registers hold into the next cycle.
  task automatic run_prog(input int waits, input bit poke_start);
    int n;
    bit have_snap;
    logic       s_req;
    logic [5:0] s_addr, s_pc;
    logic [7:0] s_acc, s_ir;
    wait_n = waits;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    have_snap = 0;
    s_req = 0; s_addr = 0; s_pc = 0; s_acc = 0; s_ir = 0;
    while (halted !== 1'b1 && n < 2000) begin
      if (have_snap) begin
        chk("wait_req",  32'(mem_req),  32'(s_req));
        chk("wait_addr", 32'(mem_addr), 32'(s_addr));
        chk("wait_acc",  32'(out_acc),  32'(s_acc));
        chk("wait_ir",   32'(out_ir),   32'(s_ir));
        chk("wait_pc",   32'(out_pc),   32'(s_pc));
      end
      have_snap = (mem_req === 1'b1) && (mem_ack === 1'b0);
      s_req = mem_req; s_addr = mem_addr; s_acc = out_acc; s_ir = out_ir; s_pc = out_pc;
      if (poke_start && n == 2) start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n++;
    end
    if (n >= 2000) chk("run_timeout", 32'(halted), 32'd1);
    run_cycles = n;
  endtask

  task automatic check_final(input int acc, input int c, input int z, input int pc,
                             input int ir, input int cyc);
    chk("acc",    32'(out_acc), acc);
    chk("carry",  32'(carry),   c);
    chk("zero",   32'(zero),    z);
    chk("pc",     32'(out_pc),  pc);
    chk("ir",     32'(out_ir),  ir);
    chk("halted", 32'(halted),  32'd1);
    chk("busy",   32'(busy),    32'd0);
    chk("cycles", run_cycles,   cyc);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},    32'(mem_req),  32'd0);
    chk({tag, "_addr"},   32'(mem_addr), 32'd0);
    chk({tag, "_acc"},    32'(out_acc),  32'd0);
    chk({tag, "_ir"},     32'(out_ir),   32'd0);
    chk({tag, "_pc"},     32'(out_pc),   32'd0);
    chk({tag, "_carry"},  32'(carry),    32'd0);
    chk({tag, "_zero"},   32'(zero),     32'd0);
    chk({tag, "_busy"},   32'(busy),     32'd0);
    chk({tag, "_halted"}, 32'(halted),   32'd0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
  endtask

  initial begin
    int n, k;
    checks = 0;
    failures = 0;
    wait_n = 0;
    start = 1'b0;
    reset_n = 1'b1;
    clear_mem();

    // Reset
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_all_zero("idle");

    // ADD then HALT, zero-wait: 3 + 2 cycles
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'hC0; mem[5] = 8'h3C;
    run_prog(0, 0);
    check_final(8'h3C, 0, 0, 2, 8'hC0, 5);

    // Carry out of the 8-bit sum (restart from HALT clears acc)
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'hC0;
    mem[8'h10] = 8'hF0; mem[8'h11] = 8'h20;
    run_prog(0, 0);
    check_final(8'h10, 1, 0, 3, 8'hC0, 8);

    // Opcode 01
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'h46; mem[2] = 8'hC0; mem[5] = 8'h3C;
`ifdef ADDM_SUB_EN
    mem[6] = 8'h3C;
    run_prog(0, 0);
    check_final(8'h00, 0, 1, 3, 8'hC0, 8);
`else
    mem[6] = 8'h0F;
    run_prog(0, 0);
    check_final(8'h0C, 0, 0, 3, 8'hC0, 8);
`endif

    // JMP and PC wrap, cycle by cycle
    clear_mem();
    mem[0] = 8'hBF; mem[8'h3F] = 8'h81; mem[1] = 8'hC0;
    wait_n = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("jmp_f0_req",  32'(mem_req),  32'd1);
    chk("jmp_f0_addr", 32'(mem_addr), 32'd0);
    @(negedge clock);
    chk("jmp_d0_req",  32'(mem_req),  32'd0);
    chk("jmp_d0_ir",   32'(out_ir),   32'hBF);
    chk("jmp_d0_pc",   32'(out_pc),   32'd1);
    @(negedge clock);
    chk("jmp_f1_req",  32'(mem_req),  32'd1);
    chk("jmp_f1_addr", 32'(mem_addr), 32'h3F);
    @(negedge clock);
    chk("wrap_pc",     32'(out_pc),   32'd0);
    chk("wrap_ir",     32'(out_ir),   32'h81);
    @(negedge clock);
    chk("jmp_f2_addr", 32'(mem_addr), 32'd1);
    chk("jmp_f2_pc",   32'(out_pc),   32'd1);
    @(negedge clock);
    chk("halt_pre",    32'(halted),   32'd0);
    @(negedge clock);
    chk("jmp_halted",  32'(halted),   32'd1);
    chk("jmp_pc",      32'(out_pc),   32'd2);
    chk("jmp_ir",      32'(out_ir),   32'hC0);

    // Wait states: 3 per access, ADD takes 9 cycles, HALT 2+3
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'hC0; mem[5] = 8'h3C;
    run_prog(3, 0);
    check_final(8'h3C, 0, 0, 2, 8'hC0, 14);

    // Reset while EXEC is waiting for its ack
    wait_n = 3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!(mem_req === 1'b1 && mem_addr === 6'd5) && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("exec_reached", 32'(n < 100), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    chk("midreset_ack", 32'(mem_ack), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_all_zero("postreset");
    run_prog(0, 0);
    check_final(8'h3C, 0, 0, 2, 8'hC0, 5);

    // Randomized programs against the reference interpreter
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      n = $urandom_range(1, 8);
      k = 0;
      while (k < n) begin
        if ($urandom_range(0, 3) == 3 && k + 2 <= n) begin
          mem[k] = 8'h80 | 8'(k + 2);
          k += 2;
        end else begin
          mem[k] = {1'b0, 1'($urandom), 6'($urandom)};
          k++;
        end
      end
      mem[n] = {2'b11, 6'($urandom)};
      k = $urandom_range(0, 2);
      model(k);
      run_prog(k, (t % 2) == 1);
      check_final(exp_acc, exp_c, exp_z, exp_pc, exp_ir, exp_cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
